manager: RTL and testbench

MANAGER -- requirements
Module: manager

---
 rtl/manager_pkg.sv | 31 +++
 rtl/manager_user.sv | 72 +++++++
 rtl/manager.sv | 209 ++++++++++++++++++++
 tb/tb_manager.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/manager_pkg.sv
// Shared constants for the elevator access manager.
// Key codes, state codes, empty-entry marker and default user table contents.
package manager_pkg;

    localparam logic [3:0]  KEY_STAR   = 4'hA;
    localparam logic [3:0]  KEY_HASH   = 4'hB;

    localparam logic [15:0] EMPTY_PASS = 16'hFFFF;
    localparam int          ROOT_USER  = 1;
    localparam logic [15:0] ROOT_PASS  = 16'h1111;
    localparam logic        ROOT_ADMIN = 1'b1;

    typedef enum logic [7:0] {
        IDLE       = 8'h00,
        GET_USER   = 8'h01,
        CHECK_USER = 8'h02,
        USER_OK    = 8'h03,
        GET_PASS   = 8'h04,
        CHECK_PASS = 8'h05,
        ADMIN      = 8'h06,
        A_USER     = 8'h07,
        A_PASS     = 8'h08,
        A_WRITE    = 8'h09
    } state_t;

    // X or any code above 9 is not a digit.
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9) === 1'b1;
    endfunction

endpackage

// File: rtl/manager_user.sv
// User table: NUM_USERS entries of {pass, count, admin, lock}.
// Async read at addr, sync per-field write on clk when cs and field rw are set;
// rst reloads the default contents (only entry ROOT_USER is populated).
// Ports: clk, rst, cs, *_rw, addr, *_in (write data), *_out (read data).
module user_ram
    import manager_pkg::*;
#(
    parameter int NUM_USERS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        pass_rw,
    input  logic        count_rw,
    input  logic        admin_rw,
    input  logic        lock_rw,
    input  logic [11:0] addr,
    input  logic [15:0] pass_in,
    input  logic [3:0]  count_in,
    input  logic        admin_in,
    input  logic        lock_in,
    output logic [15:0] pass_out,
    output logic [3:0]  count_out,
    output logic        admin_out,
    output logic        lock_out
);

    localparam int AW = $clog2(NUM_USERS);

    logic [15:0] pass_mem  [NUM_USERS];
    logic [3:0]  count_mem [NUM_USERS];
    logic        admin_mem [NUM_USERS];
    logic        lock_mem  [NUM_USERS];

    logic          valid;
    logic [AW-1:0] idx;

    // Usernames are BCD, so only 000..(NUM_USERS-1) map to a slot.
    assign valid = (addr[11:4] == 8'd0) &&
                   ({28'd0, addr[3:0]} < NUM_USERS);
    assign idx   = addr[AW-1:0];

    always_comb begin
        pass_out  = EMPTY_PASS;
        count_out = 4'd0;
        admin_out = 1'b0;
        lock_out  = 1'b0;
        if (valid) begin
            pass_out  = pass_mem[idx];
            count_out = count_mem[idx];
            admin_out = admin_mem[idx];
            lock_out  = lock_mem[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                pass_mem[i]  <= (i == ROOT_USER) ? ROOT_PASS : EMPTY_PASS;
                count_mem[i] <= 4'd0;
                admin_mem[i] <= (i == ROOT_USER) ? ROOT_ADMIN : 1'b0;
                lock_mem[i]  <= 1'b0;
            end
        end else if (cs && valid) begin
            if (pass_rw)  pass_mem[idx]  <= pass_in;
            if (count_rw) count_mem[idx] <= count_in;
            if (admin_rw) admin_mem[idx] <= admin_in;
            if (lock_rw)  lock_mem[idx]  <= lock_in;
        end
    end

endmodule

// File: rtl/manager.sv
// Keypad-driven elevator access manager with login, lockout and admin user entry.
// Ports: in (key), state/prev_state, saved_username/password, user-table mirror, enable.
module manager
    import manager_pkg::*;
#(
    parameter int MAX_TRIES = 3,
    parameter int NUM_USERS = 10
) (
    input  logic [3:0]  in,
    output logic [7:0]  state,
    output logic [7:0]  prev_state,
    output logic [11:0] saved_username,
    output logic [15:0] saved_password,
    output logic        cs,
    output logic        pass_rw,
    output logic        admin_rw,
    output logic        lock_rw,
    output logic        count_rw,
    output logic        ram_rst,
    output logic [11:0] addr,
    output logic [15:0] pass_in,
    output logic [3:0]  count_in,
    output logic        admin_in,
    output logic        lock_in,
    output logic [15:0] pass_out,
    output logic [3:0]  count_out,
    output logic        admin_out,
    output logic        lock_out,
    output logic        enable,
    input  logic        clk,
    input  logic        rst
);

    state_t      cur, nxt, prv;
    logic [11:0] user_q, user_d;
    logic [15:0] pass_q, pass_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        digit, star, hash;
    logic        user_missing, pass_match, lock_now;
    logic [3:0]  tries;

    assign digit = is_digit(in);
    assign star  = (in == KEY_STAR);
    assign hash  = (in == KEY_HASH);

    assign state          = cur;
    assign prev_state     = prv;
    assign saved_username = user_q;
    assign saved_password = pass_q;
    assign addr           = user_q;
    assign ram_rst        = rst;

    assign user_missing = (addr[11:4] != 8'd0) ||
                          ({28'd0, addr[3:0]} >= NUM_USERS) ||
                          (pass_out == EMPTY_PASS);
    assign pass_match   = (pass_out == pass_q);
    assign tries        = count_out + 4'd1;
    assign lock_now     = ({28'd0, tries} >= MAX_TRIES);

    always_comb begin
        nxt      = cur;
        user_d   = user_q;
        pass_d   = pass_q;
        cnt_d    = cnt_q;
        cs       = 1'b0;
        pass_rw  = 1'b0;
        admin_rw = 1'b0;
        lock_rw  = 1'b0;
        count_rw = 1'b0;
        pass_in  = 16'd0;
        count_in = 4'd0;
        admin_in = 1'b0;
        lock_in  = 1'b0;
        enable   = 1'b0;
        unique case (cur)
            IDLE: begin
                if (star) begin
                    nxt    = GET_USER;
                    user_d = 12'd0;
                    cnt_d  = 3'd0;
                end
            end
            GET_USER, A_USER: begin
                if (digit) begin
                    user_d = {user_q[7:0], in};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd2) begin
                        cnt_d = 3'd0;
                        if (cur == GET_USER) begin
                            nxt = CHECK_USER;
                        end else begin
                            nxt    = A_PASS;
                            pass_d = 16'd0;
                        end
                    end
                end else if (hash) begin
                    nxt = (cur == GET_USER) ? IDLE : ADMIN;
                end
            end
            GET_PASS, A_PASS: begin
                if (digit) begin
                    pass_d = {pass_q[11:0], in};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        cnt_d = 3'd0;
                        nxt   = (cur == GET_PASS) ? CHECK_PASS : A_WRITE;
                    end
                end else if (hash) begin
                    nxt = (cur == GET_PASS) ? USER_OK : ADMIN;
                end
            end
            CHECK_USER: begin
                cs  = 1'b1;
                nxt = (user_missing || lock_out) ? IDLE : USER_OK;
            end
            USER_OK: begin
                enable = 1'b1;
                if (star) begin
                    nxt    = GET_PASS;
                    pass_d = 16'd0;
                    cnt_d  = 3'd0;
                end else if (hash) begin
                    nxt = IDLE;
                end
            end
            CHECK_PASS: begin
                cs = 1'b1;
                if (pass_match) begin
                    if (admin_out) begin
                        count_rw = 1'b1;
                        nxt      = ADMIN;
                    end else begin
                        nxt = USER_OK;
                    end
                end else begin
                    count_rw = 1'b1;
                    count_in = tries;
                    if (lock_now) begin
                        lock_rw = 1'b1;
                        lock_in = 1'b1;
                        nxt     = IDLE;
                    end else begin
                        nxt = USER_OK;
                    end
                end
            end
            ADMIN: begin
                enable = 1'b1;
                if (star) begin
                    nxt    = A_USER;
                    user_d = 12'd0;
                    cnt_d  = 3'd0;
                end else if (hash) begin
                    nxt = IDLE;
                end
            end
            A_WRITE: begin
                // Creates or overwrites the entry as a plain unlocked user.
                cs       = 1'b1;
                pass_rw  = 1'b1;
                admin_rw = 1'b1;
                lock_rw  = 1'b1;
                count_rw = 1'b1;
                pass_in  = pass_q;
                nxt      = ADMIN;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur    <= IDLE;
            prv    <= IDLE;
            user_q <= 12'd0;
            pass_q <= 16'd0;
            cnt_q  <= 3'd0;
        end else begin
            cur    <= nxt;
            prv    <= cur;
            user_q <= user_d;
            pass_q <= pass_d;
            cnt_q  <= cnt_d;
        end
    end

    user_ram #(
        .NUM_USERS(NUM_USERS)
    ) u_ram (
        .clk      (clk),
        .rst      (ram_rst),
        .cs       (cs),
        .pass_rw  (pass_rw),
        .count_rw (count_rw),
        .admin_rw (admin_rw),
        .lock_rw  (lock_rw),
        .addr     (addr),
        .pass_in  (pass_in),
        .count_in (count_in),
        .admin_in (admin_in),
        .lock_in  (lock_in),
        .pass_out (pass_out),
        .count_out(count_out),
        .admin_out(admin_out),
        .lock_out (lock_out)
    );

endmodule

// File: tb/tb_manager.sv
// Testbench for manager: directed login/admin/lockout scenarios plus
// random keystrokes and resets, checked against a behavioural model.
module tb_manager;

    localparam int MAXT = 3;
    localparam int NU   = 10;
    localparam logic [3:0] NK = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in;
    logic [7:0]  state, prev_state;
    logic [11:0] saved_username, addr;
    logic [15:0] saved_password, pass_in, pass_out;
    logic        cs, pass_rw, admin_rw, lock_rw, count_rw, ram_rst;
    logic [3:0]  count_in, count_out;
    logic        admin_in, lock_in, admin_out, lock_out, enable;

    manager #(.MAX_TRIES(MAXT), .NUM_USERS(NU)) dut (
        .in(in), .state(state), .prev_state(prev_state),
        .saved_username(saved_username), .saved_password(saved_password),
        .cs(cs), .pass_rw(pass_rw), .admin_rw(admin_rw),
        .lock_rw(lock_rw), .count_rw(count_rw), .ram_rst(ram_rst),
        .addr(addr), .pass_in(pass_in), .count_in(count_in),
        .admin_in(admin_in), .lock_in(lock_in), .pass_out(pass_out),
        .count_out(count_out), .admin_out(admin_out),
        .lock_out(lock_out), .enable(enable), .clk(clk), .rst(rst)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Model: state as plain numbers, digits collected in a queue,
    // user table as arrays indexed by the numeric username.
    int          m_st, m_prev;
    logic [11:0] m_user;
    logic [15:0] m_pw;
    int          dq[$];
    logic [15:0] t_pass[NU];
    int          t_cnt[NU];
    bit          t_admin[NU], t_lock[NU];

    task automatic model_reset();
        m_st = 0; m_prev = 0; m_user = 0; m_pw = 0;
        dq.delete();
        for (int i = 0; i < NU; i++) begin
            t_pass[i]  = (i == 1) ? 16'h1111 : 16'hFFFF;
            t_cnt[i]   = 0;
            t_admin[i] = (i == 1);
            t_lock[i]  = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] k);
        int  ns = m_st;
        int  u  = int'(m_user);
        bit  dg = (k <= 4'd9);
        case (m_st)
            0: if (k == 4'hA) begin ns = 1; m_user = 0; dq.delete(); end
            1, 7: begin
                if (dg) begin
                    dq.push_back(int'(k));
                    m_user = {m_user[7:0], k};
                    if (dq.size() == 3) begin
                        dq.delete();
                        ns = (m_st == 1) ? 2 : 8;
                        if (ns == 8) m_pw = 0;
                    end
                end else if (k == 4'hB) ns = (m_st == 1) ? 0 : 6;
            end
            4, 8: begin
                if (dg) begin
                    dq.push_back(int'(k));
                    m_pw = {m_pw[11:0], k};
                    if (dq.size() == 4) begin
                        dq.delete();
                        ns = (m_st == 4) ? 5 : 9;
                    end
                end else if (k == 4'hB) ns = (m_st == 4) ? 3 : 6;
            end
            2: ns = (u < NU && t_pass[u] != 16'hFFFF && !t_lock[u]) ? 3 : 0;
            3: begin
                if (k == 4'hA) begin ns = 4; m_pw = 0; dq.delete(); end
                else if (k == 4'hB) ns = 0;
            end
            5: begin
                if (t_pass[u] == m_pw) begin
                    if (t_admin[u]) begin t_cnt[u] = 0; ns = 6; end
                    else ns = 3;
                end else begin
                    t_cnt[u] = t_cnt[u] + 1;
                    if (t_cnt[u] >= MAXT) begin t_lock[u] = 1; ns = 0; end
                    else ns = 3;
                end
            end
            6: begin
                if (k == 4'hA) begin ns = 7; m_user = 0; dq.delete(); end
                else if (k == 4'hB) ns = 0;
            end
            9: begin
                if (u < NU) begin
                    t_pass[u] = m_pw; t_admin[u] = 0;
                    t_lock[u] = 0; t_cnt[u] = 0;
                end
                ns = 6;
            end
            default: ns = 0;
        endcase
        m_prev = m_st;
        m_st   = ns;
    endtask

    task automatic check_all();
        int u = int'(m_user);
        check("state", 32'(state), 32'(m_st));
        check("prev_state", 32'(prev_state), 32'(m_prev));
        check("username", 32'(saved_username), 32'(m_user));
        check("password", 32'(saved_password), 32'(m_pw));
        check("addr", 32'(addr), 32'(m_user));
        check("enable", 32'(enable), 32'(m_st == 3 || m_st == 6));
        check("cs", 32'(cs), 32'(m_st == 2 || m_st == 5 || m_st == 9));
        check("pass_rw", 32'(pass_rw), 32'(m_st == 9));
        check("ram_rst", 32'(ram_rst), 32'(rst));
        if (u < NU) begin
            check("pass_out", 32'(pass_out), 32'(t_pass[u]));
            check("count_out", 32'(count_out), 32'(t_cnt[u] & 15));
            check("admin_out", 32'(admin_out), 32'(t_admin[u]));
            check("lock_out", 32'(lock_out), 32'(t_lock[u]));
        end else begin
            check("pass_out_miss", 32'(pass_out), 32'hFFFF);
        end
    endtask

    // Called near the falling edge: drive, clock, then compare.
    task automatic press(input logic [3:0] k);
        in = k;
        @(posedge clk);
        model_step(k);
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic keys(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) press(w[4*(n-1-i) +: 4]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in  = NK;
        @(negedge clk);
        do_reset();

        keys(32'hA002, 4); press(NK);
        check("nouser_idle", 32'(state), 32'h0);

        keys(32'hA001, 4); press(NK);
        check("user1_ok", 32'(state), 32'h3);
        check("user1_addr", 32'(addr), 32'h001);

        keys(32'hA1111, 5); press(NK);
        check("admin_state", 32'(state), 32'h6);
        check("admin_pw", 32'(saved_password), 32'h1111);

        keys(32'hA003, 4); keys(32'h4567, 4); press(NK);
        check("new_user_pass", 32'(pass_out), 32'h4567);
        keys(32'hBA003, 5); press(NK);
        check("user3_ok", 32'(state), 32'h3);

        for (int t = 0; t < 3; t++) begin
            keys(32'hA0203, 5); press(NK);
        end
        check("user3_locked", 32'(lock_out), 32'h1);
        keys(32'hA003, 4); press(NK);
        check("locked_idle", 32'(state), 32'h0);

        // Async reset in the middle of a username.
        keys(32'hA0, 2);
        #2 do_reset();
        check("rst_user", 32'(saved_username), 32'h0);
        keys(32'hA001, 4); press(NK);
        keys(32'hA1111, 5); press(NK);
        check("root_restored", 32'(state), 32'h6);

        for (int it = 0; it < 3000; it++) begin
            int r = $urandom_range(0, 99);
            logic [3:0] k;
            if (it % 250 == 249) begin
                keys(32'hA001, 4); press(NK);
                keys(32'hA1111, 5); press(NK);
                keys(32'hA00, 3);
                press(4'($urandom_range(0, 9)));
                for (int j = 0; j < 4; j++) press(4'($urandom_range(0, 3)));
                continue;
            end
            if (r < 2) begin
                #($urandom_range(1, 4)) do_reset();
                continue;
            end
            if (r < 17)      k = 4'hA;
            else if (r < 27) k = 4'hB;
            else if (r < 35) k = 4'($urandom_range(12, 15));
            else if (r < 60) k = 4'h0;
            else if (r < 75) k = 4'h1;
            else             k = 4'($urandom_range(0, 9));
            press(k);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
